// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: issues one imem request at a time for the
// current PC, computes the value the PC register loads next, and owns the
// IF/ID pipeline register (stall hold, redirect flush).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,  // informational only
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,            // asynchronous, active-low
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic        if_id_valid_q;
  logic [31:0] if_id_instr_q, if_id_pc4_q;

  logic [31:0] pc4;
  logic [31:0] tgt;
  logic        load_new;   // response goes straight into IF/ID
  logic        load_buf;   // buffered response goes into IF/ID

  assign pc4       = pc + 32'd4;   // wraps modulo 2^32
  assign tgt       = {redirect_target[31:2], 2'b00};
  assign imem_addr = {pc[31:2], 2'b00};

  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;

  // Next-state, next PC and request strobe; redirect always wins the next PC.
  always_comb begin
    state_d    = state_q;
    hold_buf_d = hold_buf_q;
    next_pc    = redirect ? tgt : pc;
    imem_req   = 1'b0;
    load_new   = 1'b0;
    load_buf   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem_req = !redirect;
        if (!redirect && imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          state_d = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid && !id_stall) begin
          load_new = 1'b1;
          next_pc  = pc4;
          state_d  = REQ;
        end else if (imem_rvalid) begin
          hold_buf_d = imem_rdata;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          hold_buf_d = 32'h0;
          state_d    = REQ;
        end else if (!id_stall) begin
          load_buf = 1'b1;
          next_pc  = pc4;
          state_d  = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and hold buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_buf_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      hold_buf_q <= hold_buf_d;
    end
  end

  // IF/ID register: flush > stall hold > load > drain to a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= 32'h0;
    end else if (redirect) begin
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
    end else if (id_stall) begin
      if_id_valid_q <= if_id_valid_q;
    end else if (load_new) begin
      if_id_valid_q <= 1'b1;
      if_id_instr_q <= imem_rdata;
      if_id_pc4_q   <= pc4;
    end else if (load_buf) begin
      if_id_valid_q <= 1'b1;
      if_id_instr_q <= hold_buf_q;
      if_id_pc4_q   <= pc4;
    end else begin
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench owns the PC register and the
// instruction memory, driving inputs at the falling edge and checking there.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .next_pc         (next_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4)
  );

  always #5 clk = ~clk;

  // PC register: loads next_pc every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'h0;
    else        pc <= next_pc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic [31:0] t, input logic st,
                       input logic rdy, input logic rv, input logic [31:0] rdat);
    redirect = rd; redirect_target = t; id_stall = st;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdat;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    // Reset state
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4",   if_id_pc4, 32'h0);
    cyc();
    reset = 1'b1;
    // Cycle 1 after deassertion: IDLE
    drive(0, 0, 0, 1, 0, 0);
    chk("idle_req", {31'b0, imem_req}, 32'h0);
    chk("idle_npc", next_pc, 32'h0);
    cyc();
    // Cycle 2: REQ, zero-wait accept
    chk("t1_req",  {31'b0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_npc0", next_pc, 32'h0);
    cyc();
    drive(0, 0, 0, 1, 1, 32'h2008_0005);
    chk("t1_wait_req", {31'b0, imem_req}, 32'h0);
    chk("t1_npc4", next_pc, 32'h4);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_valid", {31'b0, if_id_valid}, 32'h1);
    chk("t1_instr", if_id_instr, 32'h2008_0005);
    chk("t1_pc4",   if_id_pc4, 32'h4);
    chk("t1_addr4", imem_addr, 32'h4);

    // Redirect in REQ to 0x40, then ready low for 3 cycles
    drive(1, 32'h40, 0, 0, 0, 0);
    chk("t2_redir_req", {31'b0, imem_req}, 32'h0);
    chk("t2_redir_npc", next_pc, 32'h40);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_flush_valid", {31'b0, if_id_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_req_hold",  {31'b0, imem_req}, 32'h1);
      chk("t2_addr_hold", imem_addr, 32'h40);
      chk("t2_npc_hold",  next_pc, 32'h40);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 0, 0);
    chk("t2_accept_req", {31'b0, imem_req}, 32'h1);
    chk("t2_accept_npc", next_pc, 32'h40);
    cyc();
    chk("t2_one_accept", {31'b0, imem_req}, 32'h0);
    cyc();
    chk("t2_still_wait", {31'b0, imem_req}, 32'h0);
    drive(0, 0, 0, 1, 1, 32'h1111_1111);
    chk("t2_npc44", next_pc, 32'h44);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_instr", if_id_instr, 32'h1111_1111);
    chk("t2_pc4",   if_id_pc4, 32'h44);

    // Stall while response arrives at 0x10
    drive(1, 32'h10, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 1, 0, 0);
    chk("t3_addr", imem_addr, 32'h10);
    cyc();
    drive(0, 0, 1, 0, 1, 32'h2222_2222);
    chk("t3_npc_rv", next_pc, 32'h10);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      chk("t3_stall_npc",   next_pc, 32'h10);
      chk("t3_stall_valid", {31'b0, if_id_valid}, 32'h0);
      chk("t3_stall_instr", if_id_instr, 32'h0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("t3_release_npc", next_pc, 32'h14);
    cyc();
    chk("t3_valid", {31'b0, if_id_valid}, 32'h1);
    chk("t3_instr", if_id_instr, 32'h2222_2222);
    chk("t3_pc4",   if_id_pc4, 32'h14);

    // Redirect in WAIT before response -> DROP
    drive(0, 0, 0, 1, 0, 0);
    cyc();
    drive(1, 32'h0000_0103, 0, 0, 0, 0);
    chk("t4_npc_tgt", next_pc, 32'h100);
    chk("t4_req",     {31'b0, imem_req}, 32'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_flush",    {31'b0, if_id_valid}, 32'h0);
    chk("t4_drop_npc", next_pc, 32'h100);
    chk("t4_drop_req", {31'b0, imem_req}, 32'h0);
    cyc();
    drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t4_late_npc", next_pc, 32'h100);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_new_req",  {31'b0, imem_req}, 32'h1);
    chk("t4_new_addr", imem_addr, 32'h100);
    chk("t4_discard_valid", {31'b0, if_id_valid}, 32'h0);
    chk("t4_discard_instr", if_id_instr, 32'h0);

    // Wrap at top of address space
    drive(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("t5_tgt", next_pc, 32'hFFFF_FFFC);
    cyc();
    drive(0, 0, 0, 1, 0, 0);
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    cyc();
    drive(0, 0, 0, 0, 1, 32'h3333_3333);
    chk("t5_npc_wrap", next_pc, 32'h0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_valid", {31'b0, if_id_valid}, 32'h1);
    chk("t5_instr", if_id_instr, 32'h3333_3333);
    chk("t5_pc4",   if_id_pc4, 32'h0);

    // Reset asserted in WAIT, rvalid during reset
    drive(0, 0, 0, 1, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_in_wait", {31'b0, imem_req}, 32'h0);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("t6_rst_instr", if_id_instr, 32'h0);
    chk("t6_rst_pc4",   if_id_pc4, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h4444_4444);
    cyc();
    chk("t6_rv_req",   {31'b0, imem_req}, 32'h0);
    chk("t6_rv_valid", {31'b0, if_id_valid}, 32'h0);
    chk("t6_rv_instr", if_id_instr, 32'h0);
    drive(0, 0, 0, 1, 0, 0);
    reset = 1'b1;
    #1;
    chk("t6_idle_req", {31'b0, imem_req}, 32'h0);
    chk("t6_idle_npc", next_pc, 32'h0);
    cyc();
    chk("t6_req_again", {31'b0, imem_req}, 32'h1);
    chk("t6_addr",      imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
